// File: rtl/mod4_seq_checker.sv
// rtl/mod4_seq_checker.sv - registers a mod-4 count, decodes phase strobes, and checks the count sequence
//
// Ports:
//   CLK     in          rising-edge clock
//   RST     in          asynchronous active-high reset
//   CNT     in  [1:0]   count from the upstream mod-4 counter
//   EN      in          upstream counter advances this cycle when 1, holds when 0
//   CLR     in          synchronous clear of ERR_CNT
//   PH      out [3:0]   one-hot decode of the registered count
//   ERR     out         one-cycle pulse on a sequence violation
//   LOCKED  out         high while the checker is locked to the sequence
//   ERR_CNT out [ERR_W-1:0] saturating violation count
module mod4_seq_checker #(
    parameter int STEP   = 1,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       CNT,
    input  logic             EN,
    input  logic             CLR,
    output logic [3:0]       PH,
    output logic             ERR,
    output logic             LOCKED,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int                 GOOD_W   = $clog2(LOCK_N + 1);
    localparam logic [1:0]         STEP_V   = 2'(STEP);
    localparam logic [GOOD_W-1:0]  GOOD_MAX = GOOD_W'(LOCK_N);
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         s;
    logic [1:0]         exp_cnt;
    logic [GOOD_W-1:0]  good;
    logic [GOOD_W-1:0]  good_nxt;
    logic [GOOD_W-1:0]  good_inc;
    logic               err_nxt;
    logic [ERR_W-1:0]   err_cnt_nxt;

    always_comb begin
        // 2-bit addition wraps naturally, giving the mod-4 expected value.
        exp_cnt     = EN ? (s + STEP_V) : s;
        good_inc    = good + 1'b1;
        state_nxt   = state;
        good_nxt    = good;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                // First sample after reset only seeds S; nothing to compare against yet.
                state_nxt = ACQ;
                good_nxt  = '0;
            end
            ACQ: begin
                if (CNT == exp_cnt) begin
                    if (good_inc == GOOD_MAX) begin
                        state_nxt = LOCK;
                        good_nxt  = '0;
                    end else begin
                        good_nxt  = good_inc;
                    end
                end else begin
                    err_nxt  = 1'b1;
                    good_nxt = '0;
                end
            end
            LOCK: begin
                if (CNT != exp_cnt) begin
                    err_nxt   = 1'b1;
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase

        // A clear coinciding with a fresh violation still records that violation.
        if (CLR) begin
            err_cnt_nxt = err_nxt ? ERR_W'(1) : '0;
        end else if (err_nxt && (ERR_CNT != ERR_MAX)) begin
            err_cnt_nxt = ERR_CNT + 1'b1;
        end else begin
            err_cnt_nxt = ERR_CNT;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            s       <= 2'd0;
            good    <= '0;
            PH      <= 4'b0000;
            ERR     <= 1'b0;
            LOCKED  <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            state   <= state_nxt;
            // S always follows CNT, so after a violation the checker resyncs to the new phase.
            s       <= CNT;
            good    <= good_nxt;
            PH      <= 4'b0001 << CNT;
            ERR     <= err_nxt;
            LOCKED  <= (state_nxt == LOCK);
            ERR_CNT <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mod4_seq_checker.sv
// tb/tb_mod4_seq_checker.sv - self-checking bench for mod4_seq_checker
module tb_mod4_seq_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] CNT;
    logic       EN;
    logic       CLR;

    logic [3:0] ph0, ph1, ph2;
    logic       err0, err1, err2;
    logic       lk0, lk1, lk2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance 0: up counter, instance 1: down counter, instance 2: up counter with 2-bit error count.
    mod4_seq_checker #(.STEP(1), .LOCK_N(4), .ERR_W(8)) u_up (
        .CLK(CLK), .RST(RST), .CNT(CNT), .EN(EN), .CLR(CLR),
        .PH(ph0), .ERR(err0), .LOCKED(lk0), .ERR_CNT(ec0));
    mod4_seq_checker #(.STEP(3), .LOCK_N(4), .ERR_W(8)) u_dn (
        .CLK(CLK), .RST(RST), .CNT(CNT), .EN(EN), .CLR(CLR),
        .PH(ph1), .ERR(err1), .LOCKED(lk1), .ERR_CNT(ec1));
    mod4_seq_checker #(.STEP(1), .LOCK_N(4), .ERR_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .CNT(CNT), .EN(EN), .CLR(CLR),
        .PH(ph2), .ERR(err2), .LOCKED(lk2), .ERR_CNT(ec2));

    always #5 CLK = ~CLK;

    // Reference model: phase 0 = waiting for first sample, 1 = acquiring, 2 = locked.
    int p_step [3] = '{1, 3, 1};
    int p_lock [3] = '{4, 4, 4};
    int p_max  [3] = '{255, 255, 3};
    int m_phase[3];
    int m_s    [3];
    int m_good [3];
    int m_ecnt [3];
    int m_err  [3];
    int m_ph   [3];

    function automatic logic [3:0] ph_of(input int i);
        case (i)
            0: return ph0;
            1: return ph1;
            default: return ph2;
        endcase
    endfunction

    function automatic logic err_of(input int i);
        case (i)
            0: return err0;
            1: return err1;
            default: return err2;
        endcase
    endfunction

    function automatic logic lk_of(input int i);
        case (i)
            0: return lk0;
            1: return lk1;
            default: return lk2;
        endcase
    endfunction

    function automatic logic [7:0] ec_of(input int i);
        case (i)
            0: return ec0;
            1: return ec1;
            default: return {6'd0, ec2};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_phase[i] = 0;
            m_s[i]     = 0;
            m_good[i]  = 0;
            m_ecnt[i]  = 0;
            m_err[i]   = 0;
            m_ph[i]    = 0;
        end
    endtask

    task automatic model_edge();
        int c, expv;
        c = int'(CNT);
        for (int i = 0; i < 3; i++) begin
            expv     = EN ? (m_s[i] + p_step[i]) % 4 : m_s[i];
            m_err[i] = 0;
            if (m_phase[i] == 0) begin
                m_phase[i] = 1;
                m_good[i]  = 0;
            end else if (c != expv) begin
                m_err[i]   = 1;
                m_good[i]  = 0;
                m_phase[i] = 1;
            end else if (m_phase[i] == 1) begin
                m_good[i] = m_good[i] + 1;
                if (m_good[i] == p_lock[i]) begin
                    m_phase[i] = 2;
                    m_good[i]  = 0;
                end
            end
            m_s[i]  = c;
            m_ph[i] = 1 << c;
            if (CLR)
                m_ecnt[i] = m_err[i];
            else if (m_err[i] == 1 && m_ecnt[i] < p_max[i])
                m_ecnt[i] = m_ecnt[i] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_ph", i),     32'(ph_of(i)),  32'(m_ph[i]));
            chk($sformatf("u%0d_err", i),    32'(err_of(i)), 32'(m_err[i]));
            chk($sformatf("u%0d_locked", i), 32'(lk_of(i)),  32'(m_phase[i] == 2));
            chk($sformatf("u%0d_errcnt", i), 32'(ec_of(i)),  32'(m_ecnt[i]));
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are checked 1 unit after the next edge.
    task automatic step(input logic [1:0] c, input logic e, input logic cl);
        CNT = c;
        EN  = e;
        CLR = cl;
        @(posedge CLK);
        if (RST) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #3 RST = 1'b1;
        #1 model_reset();
        check_all();
        step(2'd0, 1'b0, 1'b0);
        #3 RST = 1'b0;
    endtask

    initial begin
        logic [1:0] c;
        logic       e;
        logic       cl;

        RST = 1'b1; CNT = 2'd0; EN = 1'b0; CLR = 1'b0;
        model_reset();
        step(2'd0, 1'b1, 1'b0);
        step(2'd0, 1'b1, 1'b0);
        chk("reset_ph", 32'(ph0), 32'd0);
        #3 RST = 1'b0;

        // Clean up-count from reset: lock after the fifth edge.
        step(2'd0, 1'b1, 1'b0);
        chk("first_ph", 32'(ph0), 32'h1);
        step(2'd1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        chk("not_locked_edge4", 32'(lk0), 32'd0);
        step(2'd0, 1'b1, 1'b0);
        chk("locked_edge5", 32'(lk0), 32'd1);
        step(2'd1, 1'b1, 1'b0);

        // Skip 1 -> 3 while locked.
        step(2'd3, 1'b1, 1'b0);
        chk("skip_err", 32'(err0), 32'd1);
        chk("skip_unlock", 32'(lk0), 32'd0);
        chk("skip_errcnt", 32'(ec0), 32'd1);
        step(2'd0, 1'b1, 1'b0);
        chk("skip_err_one_cycle", 32'(err0), 32'd0);
        step(2'd1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        chk("relock", 32'(lk0), 32'd1);

        // EN stall: holding is good, moving while disabled is a violation.
        step(2'd0, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'd2, 1'b0, 1'b0);
            chk("stall_no_err", 32'(err0), 32'd0);
        end
        step(2'd3, 1'b0, 1'b0);
        chk("stall_move_err", 32'(err0), 32'd1);

        // CLR alone.
        step(2'd3, 1'b0, 1'b1);
        chk("clr_alone", 32'(ec0), 32'd0);

        // Five violations: 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) step(2'd3, 1'b1, 1'b0);
        chk("sat_errcnt", 32'(ec2), 32'd3);
        chk("nosat_errcnt", 32'(ec0), 32'd5);

        // CLR together with a violation.
        step(2'd3, 1'b1, 1'b1);
        chk("clr_with_err_cnt", 32'(ec0), 32'd1);
        chk("clr_with_err_pulse", 32'(err0), 32'd1);

        // Down count from reset locks without error.
        async_reset();
        step(2'd3, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b0);
        step(2'd0, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        chk("down_locked", 32'(lk1), 32'd1);
        chk("down_errcnt", 32'(ec1), 32'd0);

        // Lock the up instance, then reset between edges.
        step(2'd0, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b0);
        chk("pre_midreset_locked", 32'(lk0), 32'd1);
        #3 RST = 1'b1;
        #1;
        chk("midreset_locked", 32'(lk0), 32'd0);
        chk("midreset_ph", 32'(ph0), 32'd0);
        chk("midreset_errcnt", 32'(ec0), 32'd0);
        model_reset();
        step(2'd2, 1'b1, 1'b0);
        #3 RST = 1'b0;
        step(2'd2, 1'b1, 1'b0);
        chk("restart_no_err", 32'(err0), 32'd0);
        step(2'd3, 1'b1, 1'b0);
        step(2'd0, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b0);
        chk("restart_locked", 32'(lk0), 32'd1);

        // Randomised: mostly legal up then down sequences with stalls, glitches and clears.
        c = 2'd2;
        for (int k = 0; k < 400; k++) begin
            e  = ($urandom_range(0, 3) != 0);
            if (e) c = (k < 200) ? c + 2'd1 : c + 2'd3;
            if ($urandom_range(0, 11) == 0) c = 2'($urandom_range(0, 3));
            cl = ($urandom_range(0, 29) == 0);
            step(c, e, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
